// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - mdu_op_e     : operation codes carried on the op bus (7 is unused)
//   - mdu_state_e  : controller FSM states
//   - DIV_BY_ZERO_QUOT : quotient written for a zero divisor
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } mdu_state_e;

    localparam logic [31:0] DIV_BY_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: request/result bundle between the core and the MDU.
//   master (core): drives op_valid, op, rs_data, rt_data;
//                  sees busy, done, HI_in, LO_in, HI_w, LO_w.
//   slave  (MDU) : the mirror image.
interface mdu_ctrl_if #(parameter int WIDTH = 32);

    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI_in;
    logic [WIDTH-1:0] LO_in;
    logic             HI_w;
    logic             LO_w;

    modport master (
        output op_valid, op, rs_data, rt_data,
        input  busy, done, HI_in, LO_in, HI_w, LO_w
    );

    modport slave (
        input  op_valid, op, rs_data, rt_data,
        output busy, done, HI_in, LO_in, HI_w, LO_w
    );

endinterface

// File: rtl/mdu_div_core.sv
// mdu_div_core: unsigned restoring divider, one quotient bit per step.
//   clk_i, rst_i : clock, async active-high reset
//   start_i      : load dividend/divisor magnitudes, clear remainder
//   step_i       : perform one restoring step
//   dvd_i, dvs_i : dividend / divisor magnitudes
//   quo_nxt_o, rem_nxt_o : quotient/remainder after the current step, so the
//                  caller can capture the final result on the last step edge
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] quo_nxt_o,
    output logic [WIDTH-1:0] rem_nxt_o
);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_sub;
    logic             ge;

    // When the partial remainder is >= divisor the true difference is below
    // the divisor, so the low WIDTH bits of the subtraction are exact.
    always_comb begin
        shifted   = {rem_q, quo_q[WIDTH-1]};
        ge        = (shifted >= {1'b0, dvs_q});
        rem_sub   = shifted[WIDTH-1:0] - dvs_q;
        rem_nxt_o = ge ? rem_sub : shifted[WIDTH-1:0];
        quo_nxt_o = {quo_q[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (start_i) begin
            rem_q <= '0;
            quo_q <= dvd_i;
            dvs_q <= dvs_i;
        end else if (step_i) begin
            rem_q <= rem_nxt_o;
            quo_q <= quo_nxt_o;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller producing HI/LO writes.
//   MDU_clk, MDU_rst : clock, async active-high reset
//   MDU_ena          : low freezes all state and masks the write strobes
//   bus (slave)      : op request in, busy/done and HI/LO write port out
// Multiply is a 32-step shift-add on operand magnitudes, divide is a 32-step
// restoring divide in mdu_div_core; signs are applied on the last step.
// Build option: define MDU_FAST_MUL_EN for a single-cycle combinational
// multiply (IDLE->DONE directly).
import mdu_pkg::*;

module mdu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic       MDU_clk,
    input  logic       MDU_rst,
    input  logic       MDU_ena,
    mdu_ctrl_if.slave  bus
);

    localparam int W2 = 2 * WIDTH;

    mdu_state_e       state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             hi_w_q, hi_w_d, lo_w_q, lo_w_d, done_q, done_d;
    logic [WIDTH-1:0] hi_in_q, hi_in_d, lo_in_q, lo_in_d;

    logic [WIDTH-1:0] mcand_q;
    logic [W2-1:0]    prod_q;
    logic             neg_q;    // negate product / quotient
    logic             rneg_q;   // negate remainder (dividend was negative)

    logic             accept, is_signed, is_div_op, dvs_zero;
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic [WIDTH:0]   sum;
    logic [W2-1:0]    prod_step, mul_res;
    logic [WIDTH-1:0] quo_nxt, rem_nxt, div_hi, div_lo;

    // Acceptance is only possible in IDLE, where busy is low by construction.
    always_comb begin
        accept    = bus.op_valid && MDU_ena && (state_q == ST_IDLE);
        is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        is_div_op = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        dvs_zero  = (bus.rt_data == '0);
        rs_neg    = is_signed && bus.rs_data[WIDTH-1];
        rt_neg    = is_signed && bus.rt_data[WIDTH-1];
        rs_mag    = rs_neg ? -bus.rs_data : bus.rs_data;
        rt_mag    = rt_neg ? -bus.rt_data : bus.rt_data;
    end

    // Shift-add step: upper half accumulates the multiplicand when the
    // multiplier LSB (low half bit 0) is set, then the whole pair shifts right.
    always_comb begin
        sum       = {1'b0, prod_q[W2-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_step = {sum, prod_q[WIDTH-1:1]};
        mul_res   = neg_q ? -prod_step : prod_step;
        div_lo    = neg_q ? -quo_nxt : quo_nxt;
        div_hi    = rneg_q ? -rem_nxt : rem_nxt;
    end

`ifdef MDU_FAST_MUL_EN
    logic [W2-1:0] fast_mag, fast_res;
    always_comb begin
        fast_mag = W2'(rs_mag) * W2'(rt_mag);
        fast_res = (rs_neg ^ rt_neg) ? -fast_mag : fast_mag;
    end
`endif

    mdu_div_core #(.WIDTH(WIDTH)) u_div (
        .clk_i     (MDU_clk),
        .rst_i     (MDU_rst),
        .start_i   (accept && is_div_op && !dvs_zero),
        .step_i    (MDU_ena && (state_q == ST_DIV)),
        .dvd_i     (rs_mag),
        .dvs_i     (rt_mag),
        .quo_nxt_o (quo_nxt),
        .rem_nxt_o (rem_nxt)
    );

    // Next state and registered HI/LO write port.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_w_d  = 1'b0;
        lo_w_d  = 1'b0;
        done_d  = 1'b0;
        hi_in_d = hi_in_q;
        lo_in_d = lo_in_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    case (mdu_op_e'(bus.op))
                        OP_MULT, OP_MULTU: begin
`ifdef MDU_FAST_MUL_EN
                            state_d              = ST_DONE;
                            {hi_w_d, lo_w_d}     = 2'b11;
                            done_d               = 1'b1;
                            {hi_in_d, lo_in_d}   = fast_res;
`else
                            state_d = ST_MUL;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            if (dvs_zero) begin
                                state_d          = ST_DONE;
                                {hi_w_d, lo_w_d} = 2'b11;
                                done_d           = 1'b1;
                                hi_in_d          = bus.rs_data;
                                lo_in_d          = DIV_BY_ZERO_QUOT;
                            end else begin
                                state_d = ST_DIV;
                            end
                        end
                        OP_MTHI: begin
                            hi_w_d  = 1'b1;
                            done_d  = 1'b1;
                            hi_in_d = bus.rs_data;
                        end
                        OP_MTLO: begin
                            lo_w_d  = 1'b1;
                            done_d  = 1'b1;
                            lo_in_d = bus.rs_data;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d            = ST_DONE;
                    {hi_w_d, lo_w_d}   = 2'b11;
                    done_d             = 1'b1;
                    {hi_in_d, lo_in_d} = mul_res;
                end
            end
            ST_DIV: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d          = ST_DONE;
                    {hi_w_d, lo_w_d} = 2'b11;
                    done_d           = 1'b1;
                    hi_in_d          = div_hi;
                    lo_in_d          = div_lo;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge MDU_clk or posedge MDU_rst) begin
        if (MDU_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_w_q  <= 1'b0;
            lo_w_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_in_q <= '0;
            lo_in_q <= '0;
        end else if (MDU_ena) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_w_q  <= hi_w_d;
            lo_w_q  <= lo_w_d;
            done_q  <= done_d;
            hi_in_q <= hi_in_d;
            lo_in_q <= lo_in_d;
        end
    end

    // Operands are captured at acceptance so later bus changes are ignored.
    always_ff @(posedge MDU_clk or posedge MDU_rst) begin
        if (MDU_rst) begin
            mcand_q <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
        end else if (accept) begin
            mcand_q <= rs_mag;
            prod_q  <= {{WIDTH{1'b0}}, rt_mag};
            neg_q   <= rs_neg ^ rt_neg;
            rneg_q  <= rs_neg;
        end else if (MDU_ena && (state_q == ST_MUL)) begin
            prod_q  <= prod_step;
        end
    end

    // Strobes are masked while disabled; the held register re-emits the
    // pulse once enable returns so a write is never lost.
    assign bus.busy  = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign bus.HI_w  = hi_w_q && MDU_ena;
    assign bus.LO_w  = lo_w_q && MDU_ena;
    assign bus.done  = done_q && MDU_ena;
    assign bus.HI_in = hi_in_q;
    assign bus.LO_in = lo_in_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic clk, rst, ena;
    int   checks = 0;
    int   errors = 0;

    mdu_ctrl_if #(.WIDTH(32)) bus ();

    mdu_ctrl #(.WIDTH(32)) dut (
        .MDU_clk (clk),
        .MDU_rst (rst),
        .MDU_ena (ena),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Results of the last run_op.
    logic [31:0] r_hi, r_lo;
    logic [2:0]  r_strb;
    logic        r_bz, r_dn2;
    int          r_cyc, r_bcnt, r_early;

    // Issue an op, then wait for done while scrambling the operand buses.
    // ena_at/ena_len drop enable for ena_len edges starting at that cycle;
    // drop_at raises a stray MTLO request at that cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int ena_at, input int ena_len, input int drop_at);
        bus.op_valid = 1'b1; bus.op = o; bus.rs_data = a; bus.rt_data = b;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        r_cyc = 1; r_bcnt = 0; r_early = 0;
        while (!bus.done && r_cyc < 200) begin
            if (bus.busy) r_bcnt++;
            if (bus.HI_w || bus.LO_w) r_early++;
            ena          = !(r_cyc >= ena_at && r_cyc < ena_at + ena_len);
            bus.op_valid = (r_cyc == drop_at);
            bus.op       = OP_MTLO;
            bus.rs_data  = $urandom;
            bus.rt_data  = $urandom;
            @(posedge clk); #1;
            r_cyc++;
        end
        ena = 1'b1; bus.op_valid = 1'b0;
        r_hi   = bus.HI_in;
        r_lo   = bus.LO_in;
        r_strb = {bus.HI_w, bus.LO_w, bus.done};
        r_bz   = bus.busy;
        @(posedge clk); #1;
        r_dn2  = bus.done || bus.HI_w || bus.LO_w;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        int          cyc;
    } vec_t;

    vec_t vecs[10];
    int   strobes;

    initial begin
        vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 33};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
        vecs[2] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
        vecs[3] = '{OP_MULT,  32'h7,        32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, 33};
        vecs[4] = '{OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[5] = '{OP_DIVU,  32'h7,        32'h2,        32'h1,        32'h3,        33};
        vecs[6] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 33};
        vecs[7] = '{OP_DIV,   32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 33};
        vecs[8] = '{OP_DIVU,  32'h1234,     32'h0,        32'h1234,     32'hFFFFFFFF, 1};
        vecs[9] = '{OP_DIV,   32'hFFFFFFF0, 32'h0,        32'hFFFFFFF0, 32'hFFFFFFFF, 1};

        rst = 1'b1; ena = 1'b1;
        bus.op_valid = 1'b0; bus.op = OP_NONE; bus.rs_data = '0; bus.rt_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy",  64'(bus.busy),  64'h0);
        check("rst done",  64'(bus.done),  64'h0);
        check("rst HI_w",  64'(bus.HI_w),  64'h0);
        check("rst LO_w",  64'(bus.LO_w),  64'h0);
        check("rst HI_in", 64'(bus.HI_in), 64'h0);
        check("rst LO_in", 64'(bus.LO_in), 64'h0);
        rst = 1'b0;

        // Multiply/divide vectors, first one issued right after reset release.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, 0);
            check($sformatf("v%0d HI", i),     64'(r_hi),    64'(vecs[i].hi));
            check($sformatf("v%0d LO", i),     64'(r_lo),    64'(vecs[i].lo));
            check($sformatf("v%0d cycle", i),  64'(r_cyc),   64'(vecs[i].cyc));
            check($sformatf("v%0d busy n", i), 64'(r_bcnt),  64'(vecs[i].cyc - 1));
            check($sformatf("v%0d strb", i),   64'(r_strb),  64'h7);
            check($sformatf("v%0d busy@done", i), 64'(r_bz), 64'h0);
            check($sformatf("v%0d early", i),  64'(r_early), 64'h0);
            check($sformatf("v%0d pulse", i),  64'(r_dn2),   64'h0);
        end

        // MTHI: written the cycle after acceptance, LO left alone.
        bus.op_valid = 1'b1; bus.op = OP_MTHI; bus.rs_data = 32'hA5A5A5A5; bus.rt_data = '0;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        check("mthi HI_w",  64'(bus.HI_w),  64'h1);
        check("mthi LO_w",  64'(bus.LO_w),  64'h0);
        check("mthi done",  64'(bus.done),  64'h1);
        check("mthi busy",  64'(bus.busy),  64'h0);
        check("mthi HI_in", 64'(bus.HI_in), 64'hA5A5A5A5);
        check("mthi LO_in", 64'(bus.LO_in), 64'hFFFFFFFF);
        @(posedge clk); #1;
        check("mthi pulse", 64'({bus.HI_w, bus.done}), 64'h0);

        // Request raised while busy must be dropped.
        run_op(OP_MULTU, 32'd5, 32'd6, 0, 0, 5);
        check("drop HI",    64'(r_hi),    64'h0);
        check("drop LO",    64'(r_lo),    64'd30);
        check("drop cycle", 64'(r_cyc),   64'd33);
        check("drop early", 64'(r_early), 64'h0);

        // Enable low for 5 cycles mid-divide delays DONE by 5.
        run_op(OP_DIVU, 32'd100, 32'd7, 10, 5, 0);
        check("ena HI",     64'(r_hi),   64'd2);
        check("ena LO",     64'(r_lo),   64'd14);
        check("ena cycle",  64'(r_cyc),  64'd38);
        check("ena busy n", 64'(r_bcnt), 64'd37);
        check("ena strb",   64'(r_strb), 64'h7);

        // Reset during a multiply at cycle N+10, then immediate MTLO.
        bus.op_valid = 1'b1; bus.op = OP_MULT; bus.rs_data = 32'h1234; bus.rt_data = 32'h5678;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("mrst busy",  64'(bus.busy),  64'h0);
        check("mrst strb",  64'({bus.HI_w, bus.LO_w, bus.done}), 64'h0);
        check("mrst HI_in", 64'(bus.HI_in), 64'h0);
        check("mrst LO_in", 64'(bus.LO_in), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.op_valid = 1'b1; bus.op = OP_MTLO; bus.rs_data = 32'h77;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        check("post rst LO_w",  64'({bus.HI_w, bus.LO_w}), 64'h1);
        check("post rst LO_in", 64'(bus.LO_in), 64'h77);
        check("post rst HI_in", 64'(bus.HI_in), 64'h0);
        strobes = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.HI_w || bus.LO_w || bus.done || bus.busy) strobes++;
        end
        check("mrst no write", 64'(strobes), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/HI/LO width; only 32 is supported.
REQ-002 SHALL have port: MDU_clk  in  1  clock; all state updates on posedge.
REQ-003 SHALL have port: MDU_rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: MDU_ena  in  1  enable; low freezes all state.
REQ-005 SHALL have port: op_valid  in  1  operation request.
REQ-006 SHALL have port: op  in  3  operation code, encoded per mdu_pkg.
REQ-007 SHALL have port: rs_data  in  32  dividend/multiplicand/MTHI/MTLO source.
REQ-008 SHALL have port: rt_data  in  32  divisor/multiplier.
REQ-009 SHALL have port: busy  out  1  high while a multi-cycle op is in flight; the core stalls on it.
REQ-010 SHALL have port: done  out  1  one-cycle pulse when HI/LO are written.
REQ-011 SHALL have ports: HI_in, LO_in  out  32 each  HI/LO register write data.
REQ-012 SHALL have ports: HI_w, LO_w  out  1 each  HI/LO register write strobes.

Function
REQ-013 SHALL use ops NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; codes 7 and 0 are ignored.
REQ-014 SHALL accept an op at a posedge only when op_valid, MDU_ena and !busy are all high in state IDLE; requests while busy are dropped.
REQ-015 SHALL implement FSM states IDLE, MUL, DIV and DONE.
REQ-016 SHALL transition IDLE->MUL on MULT/MULTU, IDLE->DIV on DIV/DIVU, MUL/DIV->DONE when the 5-bit counter reaches 31, and DONE->IDLE unconditionally.
REQ-017 SHALL service MTHI/MTLO from IDLE without leaving IDLE: one cycle after acceptance drive HI_w (MTHI) or LO_w (MTLO) high for one cycle with HI_in/LO_in = rs_data, pulse done, and keep busy low.
REQ-018 SHALL implement iterative multiply as 32 shift-add steps, {HI,LO} = 64-bit product; MULT is signed two's complement, MULTU unsigned.
REQ-019 SHALL implement iterative divide as a 32-step restoring divide with LO=quotient and HI=remainder.
REQ-020 SHALL, for signed DIV, divide operand magnitudes, negate the quotient when the operand signs differ, and give the remainder the dividend's sign; 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-021 SHALL treat a zero divisor as follows: DIV/DIVU go IDLE->DONE directly (no DIV state), with LO=0xFFFFFFFF and HI=rs_data.
REQ-022 SHALL time MUL/DIV ops as: accept at edge N; busy=1 during cycles N+1..N+32; DONE at cycle N+33 with HI_w=LO_w=done=1 and busy=0.
REQ-023 SHALL register HI_in/LO_in/HI_w/LO_w/done; the strobes are high only in DONE or on the MTHI/MTLO cycle and are 0 otherwise; the data outputs hold their last value.
REQ-024 SHALL, while MDU_ena=0, hold state, counter and datapath registers and force HI_w/LO_w/done to 0; busy keeps its value.
REQ-025 SHALL latch operands at acceptance; changes on rs_data/rt_data during an op have no effect.

Reset
REQ-026 SHALL, on MDU_rst=1 at any time including mid-operation, go immediately to IDLE, clear the counter and datapath registers, and drive busy=0, done=0, HI_w=0, LO_w=0, HI_in=0, LO_in=0; no partial result is written.
REQ-027 SHALL accept a new op at the first posedge after MDU_rst deasserts.

Configuration
REQ-028 SHALL, when MDU_FAST_MUL_EN is defined, compute MULT/MULTU combinationally in one cycle and go IDLE->DONE directly (DONE at N+1, busy never high); when it is undefined, REQ-018/022 timing applies. Divide is unaffected either way.

Structure
REQ-029 SHALL place the op encodings, FSM state typedef and the DIV_BY_ZERO_QUOT constant (0xFFFFFFFF) in shared package mdu_pkg.
REQ-030 SHALL implement the restoring divide step logic and its remainder/quotient registers in sub-module mdu_div_core; the multiplier and FSM stay in mdu_ctrl.

Verification
REQ-031 SHALL check: MULT rs=0xFFFFFFFE, rt=3 -> at N+33 HI=0xFFFFFFFF, LO=0xFFFFFFFA, HI_w=LO_w=done=1, with busy high for exactly 32 cycles.
REQ-032 SHALL check: DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU rs=7, rt=2 -> LO=3, HI=1.
REQ-033 SHALL check: DIVU rs=0x1234, rt=0 -> DONE at N+1 with LO=0xFFFFFFFF, HI=0x1234, busy never high.
REQ-034 SHALL check: MTHI rs=0xA5A5A5A5 -> next cycle HI_w=1, LO_w=0, HI_in=0xA5A5A5A5; a second op_valid while busy is dropped.
REQ-035 SHALL check: MDU_rst pulsed at cycle N+10 of a MULT -> all outputs 0 and no HI_w/LO_w ever pulses for that op.
REQ-036 SHALL check: MDU_ena low for 5 cycles mid-DIV -> DONE delayed by exactly 5 cycles and the result is unchanged.
